// File: rtl/bp_cfg_param_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bp_cfg_param_streamer                                         |
// | Purpose  : Reads one configuration record from a synchronous ROM and     |
// |            streams it LSW-first over valid/ready; bad IDs get 1 err word. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bp_cfg_param_streamer #(
    parameter int CFG_WIDTH   = 512,
    parameter int WORD_WIDTH  = 64,
    parameter int NUM_CFGS    = 16,
    parameter int LG_NUM_CFGS = (NUM_CFGS > 1) ? $clog2(NUM_CFGS) : 1,
    parameter int NUM_WORDS   = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   req_v_i,
    input  logic [LG_NUM_CFGS-1:0] req_id_i,
    output logic                   req_ready_o,
    output logic                   rom_r_v_o,
    output logic [LG_NUM_CFGS-1:0] rom_addr_o,
    input  logic [CFG_WIDTH-1:0]   rom_data_i,
    output logic                   word_v_o,
    output logic [WORD_WIDTH-1:0]  word_o,
    output logic                   word_last_o,
    output logic                   word_err_o,
    input  logic                   word_ready_i
);

    localparam int C_CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int C_BUF_W = NUM_WORDS * WORD_WIDTH;
    localparam int C_PAD_W = C_BUF_W - CFG_WIDTH;
    localparam logic [C_CNT_W-1:0]   C_LAST_CNT = C_CNT_W'(NUM_WORDS - 1);
    localparam logic [LG_NUM_CFGS:0] C_NUM_CFGS = (LG_NUM_CFGS + 1)'(NUM_CFGS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LG_NUM_CFGS-1:0] r_id;
    logic [C_BUF_W-1:0]     r_shift;
    logic [C_BUF_W-1:0]     w_rom_ext;
    logic [C_CNT_W-1:0]     r_cnt;
    logic                   w_id_bad;
    logic                   w_last;

    // Pad the record up to a whole number of words so the final word's upper bits read as 0.
    generate
        if (C_PAD_W > 0) begin : g_pad
            assign w_rom_ext = {{C_PAD_W{1'b0}}, rom_data_i};
        end else begin : g_nopad
            assign w_rom_ext = rom_data_i;
        end
    endgenerate

    assign w_id_bad = (req_id_i == '0) || ({1'b0, req_id_i} >= C_NUM_CFGS);
    assign w_last   = (r_cnt == C_LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rom_r_v_o   = 1'b0;
        rom_addr_o  = '0;
        word_v_o    = 1'b0;
        word_o      = '0;
        word_last_o = 1'b0;
        word_err_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_v_i) begin
                    w_state_nxt = w_id_bad ? S_ERR : S_FETCH;
                end
            end
            S_FETCH: begin
                rom_r_v_o   = 1'b1;
                rom_addr_o  = r_id;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                word_v_o    = 1'b1;
                word_o      = r_shift[WORD_WIDTH-1:0];
                word_last_o = w_last;
                if (word_ready_i && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                word_v_o    = 1'b1;
                word_last_o = 1'b1;
                word_err_o  = 1'b1;
                if (word_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req_v_i) begin
                        r_id <= req_id_i;
                    end
                end
                S_LOAD: begin
                    r_shift <= w_rom_ext;
                    r_cnt   <= '0;
                end
                S_SEND: begin
                    // Counter stops on the last word so it never wraps inside a response.
                    if (word_ready_i && !w_last) begin
                        r_shift <= r_shift >> WORD_WIDTH;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_param_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bp_cfg_param_streamer                                      |
// | Purpose  : Randomized and directed bench with a transaction-level model. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bp_cfg_param_streamer;

    localparam int CW  = 512;
    localparam int WW  = 64;
    localparam int NC  = 10;
    localparam int LG  = 4;
    localparam int NW  = 8;
    localparam int CWB = 100;
    localparam int NCB = 4;
    localparam int LGB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, req_v, req_ready, rom_r_v, word_v, word_last, word_err, word_ready;
    logic [LG-1:0] req_id, rom_addr;
    logic [CW-1:0] rom_data;
    logic [WW-1:0] word;

    logic           req_v_b, req_ready_b, rom_r_v_b, word_v_b, word_last_b, word_err_b, word_ready_b;
    logic [LGB-1:0] req_id_b, rom_addr_b;
    logic [CWB-1:0] rom_data_b;
    logic [WW-1:0]  word_b;

    bp_cfg_param_streamer #(.CFG_WIDTH(CW), .WORD_WIDTH(WW), .NUM_CFGS(NC)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_id_i(req_id),
        .req_ready_o(req_ready), .rom_r_v_o(rom_r_v), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .word_v_o(word_v), .word_o(word),
        .word_last_o(word_last), .word_err_o(word_err), .word_ready_i(word_ready)
    );

    bp_cfg_param_streamer #(.CFG_WIDTH(CWB), .WORD_WIDTH(WW), .NUM_CFGS(NCB)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v_b), .req_id_i(req_id_b),
        .req_ready_o(req_ready_b), .rom_r_v_o(rom_r_v_b), .rom_addr_o(rom_addr_b),
        .rom_data_i(rom_data_b), .word_v_o(word_v_b), .word_o(word_b),
        .word_last_o(word_last_b), .word_err_o(word_err_b), .word_ready_i(word_ready_b)
    );

    // ROMs: correct data only in the cycle after a read, garbage otherwise.
    logic [CW-1:0] rom [NC];
    always @(posedge clk) begin
        if (rom_r_v && int'(rom_addr) < NC) rom_data <= rom[rom_addr];
        else rom_data <= {16{$urandom()}};
        if (rom_r_v_b) rom_data_b <= {CWB{1'b1}};
        else rom_data_b <= {$urandom(), $urandom(), $urandom(), 4'($urandom())};
    end

    typedef struct packed {
        logic          err;
        logic          last;
        logic [WW-1:0] data;
    } mword_t;

    typedef struct {
        int            cyc;
        logic          err;
        logic          last;
        logic [WW-1:0] data;
    } obs_t;

    mword_t        mq[$];
    int            m_wait = 0;
    logic [LG-1:0] m_id = '0;
    int            acc_cnt = 0;
    bit            started = 1'b0;
    int            cyc = 0;
    int            rom_cnt = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    obs_t          obs_q[$];
    obs_t          obsb_q[$];

    // Response model: a queue of pending words plus the fixed fetch delay.
    always @(posedge clk) begin
        mword_t w;
        if (!reset_n) begin
            mq.delete();
            m_wait  = 0;
            started = 1'b1;
        end else if (started) begin
            if (mq.size() > 0 && m_wait == 0 && word_ready) begin
                void'(mq.pop_front());
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (mq.size() == 0 && req_v) begin
                acc_cnt++;
                if (req_id == '0 || int'(req_id) >= NC) begin
                    w.err = 1'b1; w.last = 1'b1; w.data = '0;
                    mq.push_back(w);
                    m_wait = 0;
                end else begin
                    m_id = req_id;
                    for (int k = 0; k < NW; k++) begin
                        w.err = 1'b0; w.last = (k == NW - 1); w.data = rom[req_id][k*WW +: WW];
                        mq.push_back(w);
                    end
                    m_wait = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic          e_v, e_last, e_err, e_rv;
        logic [WW-1:0] e_word;
        logic [LG-1:0] e_addr;
        logic [72:0]   act, exp;
        cyc++;
        if (started) begin
            e_v    = (mq.size() > 0) && (m_wait == 0);
            e_word = e_v ? mq[0].data : '0;
            e_last = e_v && mq[0].last;
            e_err  = e_v && mq[0].err;
            e_rv   = (m_wait == 2);
            e_addr = e_rv ? m_id : '0;
            exp = {mq.size() == 0, e_rv, e_addr, e_v, e_last, e_err, e_word};
            act = {req_ready, rom_r_v, rom_addr, word_v, word_last, word_err, word};
            n_checks++;
            if (act === exp) n_pass++;
            else $display("FAIL cycle %0d outputs {rdy,romv,addr,v,last,err,word}: got %h expected %h", cyc, act, exp);
            if (rom_r_v) rom_cnt++;
            if (word_v && word_ready) obs_q.push_back('{cyc, word_err, word_last, word});
            if (word_v_b && word_ready_b) obsb_q.push_back('{cyc, word_err_b, word_last_b, word_b});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int bound);
        for (int i = 0; i < bound && obs_q.size() < n; i++) step();
    endtask

    function automatic logic [WW-1:0] rword(input int id, input int k);
        logic [CW-1:0] r;
        r = rom[id];
        return r[k*WW +: WW];
    endfunction

    initial begin
        int            t0;
        int            base;
        logic [5:0]    pat;
        logic [WW-1:0] v;
        for (int i = 0; i < NC; i++)
            for (int k = 0; k < NW; k++) rom[i][k*WW +: WW] = {$urandom(), $urandom()};
        for (int k = 0; k < NW; k++) begin
            v = 64'h1111_0000_0000_0000 + 64'(k);
            rom[2][k*WW +: WW] = v;
        end
        reset_n = 1'b0; req_v = 1'b0; req_id = '0; word_ready = 1'b0;
        req_v_b = 1'b0; req_id_b = '0; word_ready_b = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: streaming with the consumer always ready
        word_ready = 1'b1; obs_q.delete();
        t0 = cyc + 1;
        req_v = 1'b1; req_id = 4'd2; step(); req_v = 1'b0;
        wait_obs(NW, 40);
        check("t1_count", 64'(obs_q.size()), 64'd8);
        if (obs_q.size() == NW) begin
            check("t1_latency", 64'(obs_q[0].cyc - t0), 64'd3);
            for (int k = 0; k < NW; k++) begin
                check("t1_word", obs_q[k].data, 64'h1111_0000_0000_0000 + 64'(k));
                check("t1_last", 64'(obs_q[k].last), 64'(k == NW - 1));
                check("t1_consec", 64'(obs_q[k].cyc - obs_q[0].cyc), 64'(k));
            end
        end
        repeat (2) step();

        // 2: stalling consumer
        obs_q.delete(); rom_cnt = 0; pat = 6'b101001;
        req_v = 1'b1; req_id = 4'd2; step(); req_v = 1'b0;
        for (int i = 0; i < 80 && obs_q.size() < NW; i++) begin
            word_ready = pat[i % 6];
            step();
        end
        word_ready = 1'b1;
        check("t2_count", 64'(obs_q.size()), 64'd8);
        for (int k = 0; k < obs_q.size(); k++)
            check("t2_word", obs_q[k].data, 64'h1111_0000_0000_0000 + 64'(k));
        check("t2_rom_pulses", 64'(rom_cnt), 64'd1);
        repeat (2) step();

        // 3: invalid and out-of-range IDs
        obs_q.delete(); rom_cnt = 0;
        t0 = cyc + 1;
        req_v = 1'b1; req_id = 4'd0; step(); req_v = 1'b0;
        wait_obs(1, 10); step();
        req_v = 1'b1; req_id = 4'd12; step(); req_v = 1'b0;
        wait_obs(2, 10);
        check("t3_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            check("t3_err_latency", 64'(obs_q[0].cyc - t0), 64'd1);
            for (int k = 0; k < 2; k++)
                check("t3_err_word", {obs_q[k].data[61:0], obs_q[k].err, obs_q[k].last}, 64'h3);
        end
        check("t3_no_rom", 64'(rom_cnt), 64'd0);
        repeat (2) step();

        // 4: padded record on the narrow instance
        word_ready_b = 1'b1; req_v_b = 1'b1; req_id_b = 2'd1; step(); req_v_b = 1'b0;
        for (int i = 0; i < 20 && obsb_q.size() < 2; i++) step();
        check("t4_count", 64'(obsb_q.size()), 64'd2);
        if (obsb_q.size() == 2) begin
            check("t4_word0", obsb_q[0].data, 64'hFFFF_FFFF_FFFF_FFFF);
            check("t4_last0", 64'(obsb_q[0].last), 64'd0);
            check("t4_word1", obsb_q[1].data, 64'h0000_000F_FFFF_FFFF);
            check("t4_last1", 64'(obsb_q[1].last), 64'd1);
        end

        // 5: reset in mid-response
        obs_q.delete();
        req_v = 1'b1; req_id = 4'd2; step(); req_v = 1'b0;
        wait_obs(3, 20);
        reset_n = 1'b0; step();
        reset_n = 1'b1; obs_q.delete();
        req_v = 1'b1; req_id = 4'd3;
        @(negedge clk);
        check("t5_v_after_reset", 64'(word_v), 64'd0);
        step(); req_v = 1'b0;
        wait_obs(NW, 40);
        check("t5_count", 64'(obs_q.size()), 64'd8);
        if (obs_q.size() > 0) check("t5_first_word", obs_q[0].data, rword(3, 0));
        repeat (2) step();

        // 6: request valid held high across two responses
        obs_q.delete(); base = acc_cnt;
        req_v = 1'b1; req_id = 4'd2; step(); req_id = 4'd3;
        for (int i = 0; i < 60 && acc_cnt < base + 2; i++) step();
        req_v = 1'b0;
        wait_obs(2 * NW, 40);
        check("t6_count", 64'(obs_q.size()), 64'd16);
        if (obs_q.size() == 2 * NW) begin
            check("t6_gap", 64'(obs_q[NW].cyc - obs_q[NW-1].cyc), 64'd4);
            check("t6_second_word0", obs_q[NW].data, rword(3, 0));
        end

        // Random traffic, stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            req_v      = ($urandom() % 3) == 0;
            req_id     = 4'($urandom());
            word_ready = ($urandom() % 4) != 0;
            reset_n    = ($urandom() % 250) != 0;
            step();
        end
        reset_n = 1'b1; req_v = 1'b0; word_ready = 1'b1;
        repeat (30) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
